// File: rtl/i2s_rx_deserializer_if.sv
// Signal bundle for the I2S receive deserializer: serial pins and controls in,
// parallel sample pair and status out.
interface i2s_rx_deserializer_if #(
  parameter int unsigned SAMPLE_WIDTH = 24
);
  logic                    enable;
  logic                    err_clr;
  logic                    i2s_bclk;
  logic                    i2s_lrclk;
  logic                    i2s_d;
  logic [SAMPLE_WIDTH-1:0] left_sample;
  logic [SAMPLE_WIDTH-1:0] right_sample;
  logic                    sample_valid;
  logic                    frame_err;
  logic                    locked;

  modport master (
    output enable, err_clr, i2s_bclk, i2s_lrclk, i2s_d,
    input  left_sample, right_sample, sample_valid, frame_err, locked
  );

  modport slave (
    input  enable, err_clr, i2s_bclk, i2s_lrclk, i2s_d,
    output left_sample, right_sample, sample_valid, frame_err, locked
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: synchronizes the async bclk/lrclk/data pins into clk, deserializes
// each slot MSB first and emits one checked left/right pair per frame.
module i2s_rx_deserializer #(
  parameter int unsigned SAMPLE_WIDTH  = 24,
  parameter int unsigned MAX_SLOT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  i2s_rx_deserializer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HUNT, LEFT, RIGHT} state_e;

  localparam logic [6:0] SW_L  = 7'(SAMPLE_WIDTH);
  localparam logic [6:0] MAX_L = 7'(MAX_SLOT_BITS);

  state_e                  state_q, state_d;
  logic                    bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic                    lr_s1_q, lr_s2_q, d_s1_q, d_s2_q;
  logic                    lr_prev_q, lr_prev_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                    valid_q, valid_d, err_q, err_d;

  logic       bit_evt, slot_start, slot_ok, overflow;
  logic       err_evt, latch_left, emit;
  logic [6:0] cnt_inc;

  // A bit event is the first clk cycle in which the synchronized bclk reads high.
  assign bit_evt    = bclk_s2_q & ~bclk_h_q;
  assign slot_start = bit_evt && (lr_s2_q != lr_prev_q);
  assign cnt_inc    = {1'b0, cnt_q} + 7'd1;
  assign slot_ok    = ({1'b0, cnt_q} >= SW_L) && ({1'b0, cnt_q} <= MAX_L);
  assign overflow   = bit_evt && !slot_start && (cnt_inc > MAX_L);

  always_comb begin
    state_d    = state_q;
    err_evt    = 1'b0;
    latch_left = 1'b0;
    emit       = 1'b0;
    unique case (state_q)
      IDLE: if (bus.enable) state_d = HUNT;
      HUNT: if (slot_start && !lr_s2_q) state_d = LEFT;
      LEFT: begin
        if (slot_start) begin
          if (slot_ok && lr_s2_q) begin
            latch_left = 1'b1;
            state_d    = RIGHT;
          end else begin
            err_evt = 1'b1;
            state_d = HUNT;
          end
        end else if (overflow) begin
          err_evt = 1'b1;
          state_d = HUNT;
        end
      end
      RIGHT: begin
        if (slot_start) begin
          if (slot_ok && !lr_s2_q) begin
            emit    = 1'b1;
            state_d = LEFT;
          end else begin
            err_evt = 1'b1;
            state_d = HUNT;
          end
        end else if (overflow) begin
          err_evt = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable overrides everything, including errors detected in the same cycle.
    if (!bus.enable) begin
      state_d    = IDLE;
      err_evt    = 1'b0;
      latch_left = 1'b0;
      emit       = 1'b0;
    end
  end

  always_comb begin
    lr_prev_d   = lr_prev_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = emit;
    err_d       = err_evt | (err_q & ~bus.err_clr);
    if (bit_evt) begin
      lr_prev_d = lr_s2_q;
      if (slot_start) begin
        cnt_d = '0;
      end else begin
        if (cnt_q != 6'h3F) cnt_d = cnt_q + 6'd1;
        if ({1'b0, cnt_q} < SW_L) shift_d = {shift_q[SAMPLE_WIDTH-2:0], d_s2_q};
      end
    end
    if (latch_left) left_hold_d = shift_q;
    if (emit) begin
      left_d  = left_hold_q;
      right_d = shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_h_q    <= 1'b0;
      lr_s1_q     <= 1'b0;
      lr_s2_q     <= 1'b0;
      d_s1_q      <= 1'b0;
      d_s2_q      <= 1'b0;
      lr_prev_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_s1_q   <= bus.i2s_bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_h_q    <= bclk_s2_q;
      lr_s1_q     <= bus.i2s_lrclk;
      lr_s2_q     <= lr_s1_q;
      d_s1_q      <= bus.i2s_d;
      d_s2_q      <= d_s1_q;
      lr_prev_q   <= lr_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.left_sample  = left_q;
  assign bus.right_sample = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.locked       = (state_q == LEFT) || (state_q == RIGHT);

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: standard I2S frames with one-bit delay,
// bclk generated at 8x and 4x clk ratios, short/long slot, reset and enable cases.
module tb_i2s_rx_deserializer;

  logic clk = 1'b0;
  logic reset;
  int   half;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  int   hold_viol = 0;
  logic [23:0] cap_l = '0, cap_r = '0, prev_l = '0, prev_r = '0;
  logic [23:0] wl, wr;

  always #5 clk = ~clk;

  i2s_rx_deserializer_if #(.SAMPLE_WIDTH(24)) bus();

  i2s_rx_deserializer #(.SAMPLE_WIDTH(24), .MAX_SLOT_BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Pulse counter, pair capture and a watch on outputs changing without a strobe.
  always @(negedge clk) begin
    if (bus.sample_valid) begin
      pulses = pulses + 1;
      cap_l  = bus.left_sample;
      cap_r  = bus.right_sample;
    end else if (!reset && (bus.left_sample !== prev_l || bus.right_sample !== prev_r)) begin
      hold_viol = hold_viol + 1;
    end
    prev_l = bus.left_sample;
    prev_r = bus.right_sample;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bitof(input logic [23:0] w, input int i);
    return (i < 24) ? w[23 - i] : 1'b0;
  endfunction

  task automatic send_bit(input logic lr, input logic dat);
    bus.i2s_bclk  = 1'b0;
    bus.i2s_lrclk = lr;
    bus.i2s_d     = dat;
    repeat (half) @(negedge clk);
    bus.i2s_bclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Left slot body, right slot, then the closing lrclk 1->0 event carrying the right LSB/pad.
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int nl, input int nr, input bit chk_long);
    for (int i = 0; i < nl - 1; i++) send_bit(1'b0, bitof(l, i));
    send_bit(1'b1, bitof(l, nl - 1));
    for (int i = 0; i < nr - 1; i++) begin
      send_bit(1'b1, bitof(r, i));
      if (chk_long && i == 31) check("long_err_after_32", 32'(bus.frame_err), 32'd0);
      if (chk_long && i == 32) check("long_err_after_33", 32'(bus.frame_err), 32'd1);
    end
    send_bit(1'b0, bitof(r, nr - 1));
    repeat (4) @(negedge clk);
  endtask

  task automatic check_pair(input string tag, input logic [23:0] l, input logic [23:0] r);
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, "_left"},   32'(cap_l),  32'(l));
    check({tag, "_right"},  32'(cap_r),  32'(r));
  endtask

  initial begin
    half          = 4;
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.err_clr   = 1'b0;
    bus.i2s_bclk  = 1'b0;
    bus.i2s_lrclk = 1'b1;
    bus.i2s_d     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left",   32'(bus.left_sample),  32'd0);
    check("rst_right",  32'(bus.right_sample), 32'd0);
    check("rst_valid",  32'(bus.sample_valid), 32'd0);
    check("rst_err",    32'(bus.frame_err),    32'd0);
    check("rst_locked", 32'(bus.locked),       32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Right-channel preroll, then the 1->0 transition HUNT waits for.
    repeat (4) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("hunt_no_pulse", 32'(pulses), 32'd0);
    check("locked_in_left", 32'(bus.locked), 32'd1);

    send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b0);
    exp_pulses = 1;
    check_pair("normal1", 24'h123456, 24'hABCDEF);
    check("normal_err", 32'(bus.frame_err), 32'd0);
    send_frame(24'h654321, 24'h0FEDCB, 32, 32, 1'b0);
    exp_pulses = 2;
    check_pair("normal2", 24'h654321, 24'h0FEDCB);

    // Short 20-bit left slot.
    send_frame(24'h111111, 24'h222222, 20, 32, 1'b0);
    check("short_err", 32'(bus.frame_err), 32'd1);
    check_pair("short_hold", 24'h654321, 24'h0FEDCB);
    check("short_out_left", 32'(bus.left_sample), 32'h654321);
    send_frame(24'h333333, 24'h444444, 32, 32, 1'b0);
    exp_pulses = 3;
    check_pair("after_short", 24'h333333, 24'h444444);
    check("err_sticky", 32'(bus.frame_err), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(bus.frame_err), 32'd0);

    // Long 40-bit right slot.
    send_frame(24'h555555, 24'h666666, 32, 40, 1'b1);
    check_pair("long_hold", 24'h333333, 24'h444444);
    send_frame(24'h777777, 24'h888888, 32, 32, 1'b0);
    exp_pulses = 4;
    check_pair("after_long", 24'h777777, 24'h888888);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;

    // Reset during a right slot.
    wl = 24'hC0FFEE;
    wr = 24'hBEEF01;
    for (int i = 0; i < 31; i++) send_bit(1'b0, bitof(wl, i));
    send_bit(1'b1, bitof(wl, 31));
    for (int i = 0; i < 10; i++) send_bit(1'b1, bitof(wr, i));
    reset = 1'b1;
    @(negedge clk);
    check("mrst_left",   32'(bus.left_sample),  32'd0);
    check("mrst_right",  32'(bus.right_sample), 32'd0);
    check("mrst_valid",  32'(bus.sample_valid), 32'd0);
    check("mrst_err",    32'(bus.frame_err),    32'd0);
    check("mrst_locked", 32'(bus.locked),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 10; i < 31; i++) send_bit(1'b1, bitof(wr, i));
    send_bit(1'b0, bitof(wr, 31));
    repeat (4) @(negedge clk);
    check("mrst_no_pulse", 32'(pulses), 32'(exp_pulses));
    send_frame(24'h9ABCDE, 24'h13579B, 32, 32, 1'b0);
    exp_pulses = 5;
    check_pair("after_rst", 24'h9ABCDE, 24'h13579B);

    // Enable low mid-left-slot for three frames.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_locked", 32'(bus.locked), 32'd0);
    for (int f = 0; f < 3; f++) send_frame(24'hDEAD00 + 24'(f), 24'hFACE00 + 24'(f), 32, 32, 1'b0);
    check("dis_no_pulse", 32'(pulses), 32'(exp_pulses));
    check("dis_locked_end", 32'(bus.locked), 32'd0);
    check("dis_hold_left", 32'(bus.left_sample), 32'h9ABCDE);
    check("dis_hold_right", 32'(bus.right_sample), 32'h13579B);
    bus.enable = 1'b1;
    send_frame(24'h010101, 24'h020202, 32, 32, 1'b0);
    check("reen_hunt_frame", 32'(pulses), 32'(exp_pulses));
    send_frame(24'h2468AC, 24'hFDB975, 32, 32, 1'b0);
    exp_pulses = 6;
    check_pair("reen", 24'h2468AC, 24'hFDB975);

    // Minimum clk:bclk ratio of 4 with random words.
    half = 2;
    for (int f = 0; f < 100; f++) begin
      wl = 24'($urandom);
      wr = 24'($urandom);
      send_frame(wl, wr, 32, 32, 1'b0);
      exp_pulses = exp_pulses + 1;
      check_pair("ratio4", wl, wr);
    end
    check("ratio4_err", 32'(bus.frame_err), 32'd0);
    check("pair_hold", 32'(hold_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
